// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch: sequential requests into a 1-cycle ROM, a small
// {pc, inst} FIFO towards decode, and redirect-driven flush/restart.
module inst_fetch_unit #(
    parameter logic [31:0] STARTADDR = 32'd0,
    parameter int          DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       irom_en,
    output logic [31:0]                irom_addr,
    input  logic [31:0]                irom_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_pc_reg, req_pc_next;
    logic          inflight_reg, inflight_next;
    logic          kill_reg, kill_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [CW:0]   limit;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    // Reset is folded in so nothing is offered to decode or the ROM while it is held.
    assign out_valid = !reset && !redirect_valid && (count_reg != '0);
    assign pop       = out_valid && out_ready;

    // Entries already held plus the one in flight, net of this cycle's pop, must leave a free slot.
    assign occupancy = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
    assign limit     = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
    assign issue     = !reset && !redirect_valid && (occupancy < limit);

    assign push      = inflight_reg && !kill_reg && !redirect_valid;

    assign irom_en   = issue;
    assign irom_addr = fetch_pc_reg;
    assign out_pc    = pc_mem[rd_ptr_reg];
    assign out_inst  = inst_mem[rd_ptr_reg];
    assign buf_count = count_reg;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        inflight_next = issue;
        kill_next     = 1'b0;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;

        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & 32'hFFFF_FFFC;
            kill_next     = inflight_reg;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (issue) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
                req_pc_next   = fetch_pc_reg;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= STARTADDR;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            kill_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            inflight_reg <= inflight_next;
            kill_reg     <= kill_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Entries are cleared on reset so the head reads as zero rather than X.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] pc_reg;
            logic [31:0] inst_reg;
            logic        write_en;

            assign write_en = push && (wr_ptr_reg == PW'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    pc_reg   <= '0;
                    inst_reg <= '0;
                end else if (write_en) begin
                    pc_reg   <= req_pc_reg;
                    inst_reg <= irom_inst;
                end
            end

            assign pc_mem[gi]   = pc_reg;
            assign inst_mem[gi] = inst_reg;
        end
    endgenerate

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_inst_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] START = 32'h0;

    logic        clk;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        irom_en;
    logic [31:0] irom_addr;
    logic [31:0] irom_inst = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  buf_count;

    inst_fetch_unit #(.STARTADDR(START), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irom_en        (irom_en),
        .irom_addr      (irom_addr),
        .irom_inst      (irom_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .buf_count      (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] inst;
    } pop_t;
    pop_t pop_log[$];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // ROM: data for a request appears in the next cycle; garbage otherwise.
    always @(posedge clk) begin
        if (irom_en) irom_inst <= rom_word(irom_addr);
        else         irom_inst <= $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: queue of buffered pcs, at most one pending ROM response.
    logic [31:0] m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_fetch = START;
    bit          m_rst_seen = 1'b0;

    always @(negedge clk) begin
        bit exp_valid, exp_pop, exp_en;
        exp_valid = !reset && !redirect_valid && (m_fifo.size() != 0);
        exp_pop   = exp_valid && out_ready;
        exp_en    = !reset && !redirect_valid &&
                    ((m_fifo.size() + m_pend.size() - (exp_pop ? 1 : 0)) < DEPTH);

        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        chk("irom_en", {31'b0, irom_en}, {31'b0, exp_en});
        chk("buf_count", {29'b0, buf_count}, 32'(m_fifo.size()));
        if (exp_en) chk("irom_addr", irom_addr, m_fetch);
        if (exp_valid) begin
            chk("out_pc", out_pc, m_fifo[0]);
            chk("out_inst", out_inst, rom_word(m_fifo[0]));
        end
        if (m_rst_seen) begin
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_inst", out_inst, 32'h0);
        end

        if (out_valid === 1'b1 && out_ready)
            pop_log.push_back('{cyc: cyc, pc: out_pc, inst: out_inst});

        if (reset) begin
            m_fifo.delete();
            m_pend.delete();
            m_fetch    = START;
            m_rst_seen = 1'b1;
        end else if (redirect_valid) begin
            m_fifo.delete();
            m_pend.delete();
            m_fetch    = redirect_pc & 32'hFFFF_FFFC;
            m_rst_seen = 1'b0;
        end else begin
            if (exp_pop) void'(m_fifo.pop_front());
            if (m_pend.size() != 0) m_fifo.push_back(m_pend.pop_front());
            if (exp_en) begin
                m_pend.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
            m_rst_seen = 1'b0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_at(input int c);
        foreach (pop_log[i]) if (pop_log[i].cyc >= c) return i;
        return -1;
    endfunction

    task automatic chk_entry(input string name, input int idx, input int exp_cyc,
                             input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        if (idx < 0 || idx >= pop_log.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: got no delivery, expected pc %h at cyc %0d", name, exp_pc, exp_cyc);
        end else begin
            chk({name, "_cyc"}, 32'(pop_log[idx].cyc), 32'(exp_cyc));
            chk({name, "_pc"}, pop_log[idx].pc, exp_pc);
            chk({name, "_inst"}, pop_log[idx].inst, exp_inst);
        end
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    initial begin
        int r, s, idx;

        // Startup after a 3-cycle reset.
        reset = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        s = cyc;
        pop_log.delete();
        repeat (8) tick();
        chk_entry("start0", 0, s + 2, 32'h0, 32'h1000_0000);
        chk_entry("start1", 1, s + 3, 32'h4, 32'h1000_0001);
        chk_entry("start2", 2, s + 4, 32'h8, 32'h1000_0002);

        // Backpressure from a fresh start.
        reset = 1'b1; out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("full_count", {29'b0, buf_count}, 32'd4);
        chk("full_irom_en", {31'b0, irom_en}, 32'd0);
        chk("full_out_pc", out_pc, 32'h0);
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        s = cyc;
        pop_log.delete();
        repeat (8) tick();
        for (int i = 0; i < 8; i++)
            chk_entry($sformatf("release%0d", i), i, s + i, 32'(4 * i), 32'h1000_0000 + 32'(i));

        // Redirect while a request is in flight.
        pop_log.delete();
        r = cyc;
        redirect_to(32'h40);
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        idx = first_at(r);
        chk_entry("redir0", idx, r + 3, 32'h40, 32'h1000_0010);
        chk_entry("redir1", idx + 1, r + 4, 32'h44, 32'h1000_0011);

        // Back-to-back redirects: the later one wins.
        pop_log.delete();
        r = cyc;
        redirect_to(32'h80);
        tick();
        redirect_to(32'h100);
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        idx = first_at(r);
        chk_entry("b2b0", idx, r + 4, 32'h100, 32'h1000_0040);
        chk_entry("b2b1", idx + 1, r + 5, 32'h104, 32'h1000_0041);

        // Misaligned target is truncated to a word address.
        pop_log.delete();
        r = cyc;
        redirect_to(32'h4B);
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        idx = first_at(r);
        chk_entry("mis0", idx, r + 3, 32'h48, 32'h1000_0012);
        chk_entry("mis1", idx + 1, r + 4, 32'h4C, 32'h1000_0013);

        // Address wrap at the top of the space.
        pop_log.delete();
        r = cyc;
        redirect_to(32'hFFFF_FFF8);
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        idx = first_at(r);
        chk_entry("wrap0", idx, r + 3, 32'hFFFF_FFF8, 32'h4FFF_FFFE);
        chk_entry("wrap1", idx + 1, r + 4, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        chk_entry("wrap2", idx + 2, r + 5, 32'h0000_0000, 32'h1000_0000);

        // Reset right after a redirect with a request in flight.
        redirect_to(32'h200);
        tick();
        redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_irom_en", {31'b0, irom_en}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_count", {29'b0, buf_count}, 32'd0);
        chk("midrst_out_pc", out_pc, 32'h0);
        chk("midrst_out_inst", out_inst, 32'h0);
        tick();
        reset = 1'b0;
        s = cyc;
        pop_log.delete();
        repeat (6) tick();
        chk_entry("midrst0", 0, s + 2, START, 32'h1000_0000);

        // Randomized soak against the model.
        for (int n = 0; n < 3000; n++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ?
                             (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            reset          = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
